// File: rtl/cascade_timer_pkg.sv
// Shared constants and helpers for the cascade_timer hierarchy.
package cascade_timer_pkg;

  localparam int unsigned DEF_SEC_MOD = 60;
  localparam int unsigned DEF_MIN_MOD = 60;
  localparam int unsigned DEF_HR_MOD  = 24;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Saturate an out-of-range stage value to the largest legal value.
  function automatic int unsigned clamp(input int unsigned val, input int unsigned modulus);
    return (val >= modulus) ? modulus - 1 : val;
  endfunction

endpackage

// File: rtl/cascade_timer_mod_stage.sv
// One modulo-MOD up/down counter stage; wrap flags a step that crosses the terminal value.
module mod_stage
  import cascade_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = DEF_SEC_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
    $error("mod_stage: MOD must lie in [2, 2**WIDTH]");
  end

  logic [WIDTH-1:0] value_q, value_d;
  logic             at_end;

  always_comb begin
    at_end  = (dir == DIR_UP) ? (value_q == TOP) : (value_q == '0);
    wrap    = step & at_end;
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = WIDTH'(clamp(32'(ld_val), MOD));
    end else if (step) begin
      if (dir == DIR_UP) value_d = at_end ? '0  : value_q + 1'b1;
      else               value_d = at_end ? TOP : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cascade_timer.sv
// Three-stage sec/min/hr up/down cascade timer with registered wrap pulses.
// Define CASCADE_TIMER_ALARM_EN to build in the sticky compare alarm.
module cascade_timer
  import cascade_timer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SEC_MOD = DEF_SEC_MOD,
  parameter int MIN_MOD = DEF_MIN_MOD,
  parameter int HR_MOD  = DEF_HR_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_sec,
  input  logic [WIDTH-1:0] ld_min,
  input  logic [WIDTH-1:0] ld_hr,
  output logic [WIDTH-1:0] sec,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] hr,
  output logic             carry_min,
  output logic             carry_hr,
  output logic             rollover
`ifdef CASCADE_TIMER_ALARM_EN
 ,input  logic             alm_wr,
  input  logic [WIDTH-1:0] alm_sec,
  input  logic [WIDTH-1:0] alm_min,
  input  logic [WIDTH-1:0] alm_hr,
  input  logic             alm_ack,
  output logic             alarm
`endif
);

  logic wrap_sec, wrap_min, wrap_hr;
  logic step_min, step_hr;
  logic count_ok;
  logic carry_min_q, carry_hr_q, rollover_q;

  assign step_min = en & wrap_sec;
  assign step_hr  = en & wrap_sec & wrap_min;
  assign count_ok = en & ~clr & ~load;

  mod_stage #(.WIDTH(WIDTH), .MOD(SEC_MOD)) u_sec (
    .clk(clk), .rst_n(rst_n), .step(en), .dir(dir), .clr(clr), .load(load),
    .ld_val(ld_sec), .value(sec), .wrap(wrap_sec)
  );

  mod_stage #(.WIDTH(WIDTH), .MOD(MIN_MOD)) u_min (
    .clk(clk), .rst_n(rst_n), .step(step_min), .dir(dir), .clr(clr), .load(load),
    .ld_val(ld_min), .value(min), .wrap(wrap_min)
  );

  mod_stage #(.WIDTH(WIDTH), .MOD(HR_MOD)) u_hr (
    .clk(clk), .rst_n(rst_n), .step(step_hr), .dir(dir), .clr(clr), .load(load),
    .ld_val(ld_hr), .value(hr), .wrap(wrap_hr)
  );

  // Stage wraps are only meaningful when the count actually advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_min_q <= 1'b0;
      carry_hr_q  <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      carry_min_q <= count_ok & wrap_sec;
      carry_hr_q  <= count_ok & wrap_min;
      rollover_q  <= count_ok & wrap_hr;
    end
  end

  assign carry_min = carry_min_q;
  assign carry_hr  = carry_hr_q;
  assign rollover  = rollover_q;

`ifdef CASCADE_TIMER_ALARM_EN
  logic [WIDTH-1:0] alm_sec_q, alm_min_q, alm_hr_q;
  logic             upd_q, alarm_q, hit;

  // upd_q marks that the values now visible came from a count or load edge.
  assign hit = upd_q & (sec == alm_sec_q) & (min == alm_min_q) & (hr == alm_hr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_sec_q <= '0;
      alm_min_q <= '0;
      alm_hr_q  <= '0;
      upd_q     <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      upd_q <= ~clr & (load | en);
      if (alm_wr) begin
        alm_sec_q <= WIDTH'(clamp(32'(alm_sec), SEC_MOD));
        alm_min_q <= WIDTH'(clamp(32'(alm_min), MIN_MOD));
        alm_hr_q  <= WIDTH'(clamp(32'(alm_hr),  HR_MOD));
      end
      if (clr)          alarm_q <= 1'b0;
      else if (hit)     alarm_q <= 1'b1;
      else if (alm_ack) alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_cascade_timer.sv
// Self-checking bench for cascade_timer against a total-seconds reference model.
module tb_cascade_timer;

  localparam int W    = 8;
  localparam int SM   = 60;
  localparam int MM   = 60;
  localparam int HM   = 24;
  localparam int NTOT = SM * MM * HM;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0, clr = 1'b0, dir = 1'b1, load = 1'b0;
  logic [W-1:0] ld_sec = '0, ld_min = '0, ld_hr = '0;
  logic [W-1:0] sec, min, hr;
  logic         carry_min, carry_hr, rollover;
`ifdef CASCADE_TIMER_ALARM_EN
  logic         alm_wr = 1'b0, alm_ack = 1'b0;
  logic [W-1:0] alm_sec = '0, alm_min = '0, alm_hr = '0;
  logic         alarm;
`endif

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;
  int  cm_cnt;

  cascade_timer #(.WIDTH(W), .SEC_MOD(SM), .MIN_MOD(MM), .HR_MOD(HM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir), .load(load),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr),
    .sec(sec), .min(min), .hr(hr),
    .carry_min(carry_min), .carry_hr(carry_hr), .rollover(rollover)
`ifdef CASCADE_TIMER_ALARM_EN
   ,.alm_wr(alm_wr), .alm_sec(alm_sec), .alm_min(alm_min), .alm_hr(alm_hr),
    .alm_ack(alm_ack), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int m);
    return (v >= m) ? m - 1 : v;
  endfunction

  function automatic int hms(input int h, input int m, input int s);
    return clampv(h, HM) * SM * MM + clampv(m, MM) * SM + clampv(s, SM);
  endfunction

  function automatic logic [W-1:0] pick(input int m);
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'(m - 1);
      2:       return W'($urandom_range(0, 255));
      default: return W'($urandom_range(0, m - 1));
    endcase
  endfunction

  // Reference model: whole time as one integer of seconds.
  int m_t, m_alm_t;
  bit m_cm, m_ch, m_ro, m_pend, m_alarm;

  always @(posedge clk or negedge rst_n) begin : model
    int nt, na;
    if (!rst_n) begin
      m_t <= 0; m_cm <= 0; m_ch <= 0; m_ro <= 0;
      m_alm_t <= 0; m_pend <= 0; m_alarm <= 0;
    end else begin
      nt = m_t;
      m_cm <= 0; m_ch <= 0; m_ro <= 0;
      if (clr) nt = 0;
      else if (load) nt = hms(ld_hr, ld_min, ld_sec);
      else if (en) begin
        if (dir) begin
          nt = (m_t + 1) % NTOT;
          m_cm <= (m_t % SM == SM - 1);
          m_ch <= (m_t % (SM * MM) == SM * MM - 1);
          m_ro <= (m_t == NTOT - 1);
        end else begin
          nt = (m_t == 0) ? NTOT - 1 : m_t - 1;
          m_cm <= (m_t % SM == 0);
          m_ch <= (m_t % (SM * MM) == 0);
          m_ro <= (m_t == 0);
        end
      end
      m_t <= nt;
      na = m_alm_t;
`ifdef CASCADE_TIMER_ALARM_EN
      if (alm_wr) na = hms(alm_hr, alm_min, alm_sec);
      if (clr)          m_alarm <= 0;
      else if (m_pend)  m_alarm <= 1;
      else if (alm_ack) m_alarm <= 0;
`endif
      m_alm_t <= na;
      m_pend  <= !clr && (load || en) && (nt == na);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sec", sec, m_t % SM);
      chk("min", min, (m_t / SM) % MM);
      chk("hr", hr, m_t / (SM * MM));
      chk("carry_min", carry_min, m_cm);
      chk("carry_hr", carry_hr, m_ch);
      chk("rollover", rollover, m_ro);
`ifdef CASCADE_TIMER_ALARM_EN
      chk("alarm", alarm, m_alarm);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; en = 0; clr = 0;
    ld_hr = W'(h); ld_min = W'(m); ld_sec = W'(s);
    tick();
    load = 0;
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hr"}, hr, h);
    chk({name, ".min"}, min, m);
    chk({name, ".sec"}, sec, s);
  endtask

  task automatic chk_pulses(input string name, input bit cm, input bit ch, input bit ro);
    chk({name, ".carry_min"}, carry_min, cm);
    chk({name, ".carry_hr"}, carry_hr, ch);
    chk({name, ".rollover"}, rollover, ro);
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk_on = 1;
    repeat (3) tick();
    chk_time("reset", 0, 0, 0);
    chk_pulses("reset", 0, 0, 0);
    rst_n = 1;

    // 60 up-counts from reset
    en = 1; dir = 1; cm_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("count60.sec", sec, i % 60);
      cm_cnt += int'(carry_min);
    end
    chk("count60.min", min, 1);
    en = 0;
    tick();
    cm_cnt += int'(carry_min);
    chk("count60.carry_count", cm_cnt, 1);

    // full rollover up
    do_load(23, 59, 59);
    chk_pulses("load_up", 0, 0, 0);
    en = 1; dir = 1;
    tick();
    chk_time("roll_up", 0, 0, 0);
    chk_pulses("roll_up", 1, 1, 1);
    en = 0;
    tick();
    chk_pulses("roll_up_after", 0, 0, 0);

    // full rollover down
    dir = 0;
    do_load(0, 0, 0);
    en = 1;
    tick();
    chk_time("roll_dn", 23, 59, 59);
    chk_pulses("roll_dn", 1, 1, 1);
    en = 0;
    tick();
    chk("roll_dn_after.rollover", rollover, 0);

    // clamped load
    do_load(30, 10, 75);
    chk_time("clamp", 23, 10, 59);
    chk_pulses("clamp", 0, 0, 0);

    // clr over load over en
    do_load(10, 20, 30);
    clr = 1; load = 1; en = 1; dir = 1;
    tick();
    chk_time("clr_all", 0, 0, 0);
    chk_pulses("clr_all", 0, 0, 0);
    clr = 0; load = 0; en = 0;
    do_load(23, 59, 59);
    clr = 1; en = 1;
    tick();
    chk_pulses("clr_wrap", 0, 0, 0);
    clr = 0; en = 0;

    // asynchronous reset mid-count
    do_load(10, 20, 30);
    en = 1; dir = 1;
    repeat (3) tick();
    #3 rst_n = 0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk_pulses("async_rst", 0, 0, 0);
    tick();
    rst_n = 1;
    tick();
    chk_time("rst_resume", 0, 0, 1);
    en = 0;

`ifdef CASCADE_TIMER_ALARM_EN
    chk("alarm_reset", alarm, 0);
    alm_wr = 1; alm_hr = 0; alm_min = 1; alm_sec = 0;
    do_load(0, 0, 58);
    alm_wr = 0;
    en = 1; dir = 1;
    tick();
    tick();
    chk_time("alm_reach", 0, 1, 0);
    chk("alm_not_yet", alarm, 0);
    en = 0;
    tick();
    chk("alm_set", alarm, 1);
    alm_ack = 1;
    tick();
    chk("alm_ack", alarm, 0);
    alm_ack = 0;
    do_load(0, 1, 0);
    alm_ack = 1;
    tick();
    chk("alm_set_wins", alarm, 1);
    alm_ack = 0;
    clr = 1;
    tick();
    chk("alm_clr", alarm, 0);
    clr = 0;
`endif

    // randomized traffic
    dir = 1;
    for (int i = 0; i < 4000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      clr  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 15) == 0);
      ld_sec = pick(SM); ld_min = pick(MM); ld_hr = pick(HM);
`ifdef CASCADE_TIMER_ALARM_EN
      alm_wr  = ($urandom_range(0, 31) == 0);
      alm_ack = ($urandom_range(0, 7) == 0);
      alm_sec = pick(SM); alm_min = pick(MM); alm_hr = pick(HM);
`endif
      tick();
    end
    en = 0; clr = 0; load = 0;
`ifdef CASCADE_TIMER_ALARM_EN
    alm_wr = 0; alm_ack = 0;
`endif
    tick();
    tick();
    chk_on = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
